// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DATA_WID normally comes from the common codebase header; a 32-bit fallback is provided.
`ifndef DATA_WID
`define DATA_WID 32
`endif

package dmem_arbiter_pkg;

  localparam int DEF_MEM_DEPTH = 11;
  localparam int DEF_MAX_WAIT  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_C) ? PORT_D : PORT_C;
  endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational winner selection between requesters C and D.
// DMEM_ARB_ROUND_ROBIN_EN selects strict alternation; otherwise C has priority with a D starvation limit.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WCNT_W   = 3
) (
  input  logic              c_req,
  input  logic              d_req,
  input  logic [WCNT_W-1:0] wait_cnt,
  input  port_e             rr_ptr,
  output logic              any_req,
  output port_e             winner,
  output logic              d_lost
);

  assign any_req = c_req | d_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic [WCNT_W-1:0] unused_wait_cnt;
  assign unused_wait_cnt = wait_cnt;

  always_comb begin
    winner = PORT_C;
    d_lost = 1'b0;
    if (c_req && d_req) begin
      winner = rr_ptr;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end
`else
  port_e unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  always_comb begin
    winner = PORT_C;
    d_lost = 1'b0;
    if (c_req && d_req) begin
      // D has lost MAX_WAIT contentions in a row: it takes this one.
      if (wait_cnt == WCNT_W'(MAX_WAIT)) begin
        winner = PORT_D;
      end else begin
        d_lost = 1'b1;
      end
    end else if (d_req) begin
      winner = PORT_D;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage (C) and the debug port (D).
// IDLE -> ACCESS -> RESP per transaction; policy in dmem_arb_pick (DMEM_ARB_ROUND_ROBIN_EN).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WID  = `DATA_WID,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [DATA_WID-1:0] c_addr,
  input  logic [DATA_WID-1:0] c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_WID-1:0] c_rdata,
  output logic                c_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_WID-1:0] d_addr,
  input  logic [DATA_WID-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_WID-1:0] d_rdata,
  output logic                d_err,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_write_data,
  output logic                mem_write_flag,
  output logic                mem_read_flag,
  input  logic [DATA_WID-1:0] mem_valM,
  input  logic                mem_dmem_error,
  output state_e              dbg_state
);

  // Handshake: a requester holds req/we/addr/wdata until its one-cycle gnt;
  // exactly one rvalid pulse to the same port follows one cycle after gnt.

  localparam int                  WCNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [DATA_WID-1:0] DEPTH_W = DATA_WID'(MEM_DEPTH);

  state_e              state_q, state_d;
  port_e               win_q, rr_q, pick_win;
  logic                we_q;
  logic [WCNT_W-1:0]   wait_q;
  logic                any_req, d_lost;
  logic                sel_we, sel_in_range, acc_err;
  logic [DATA_WID-1:0] sel_addr, sel_wdata, acc_rdata;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WCNT_W   (WCNT_W)
  ) u_pick (
    .c_req    (c_req),
    .d_req    (d_req),
    .wait_cnt (wait_q),
    .rr_ptr   (rr_q),
    .any_req  (any_req),
    .winner   (pick_win),
    .d_lost   (d_lost)
  );

  assign sel_we       = (pick_win == PORT_D) ? d_we    : c_we;
  assign sel_addr     = (pick_win == PORT_D) ? d_addr  : c_addr;
  assign sel_wdata    = (pick_win == PORT_D) ? d_wdata : c_wdata;
  assign sel_in_range = (sel_addr < DEPTH_W);

  // mem_addr holds the latched address throughout ACCESS; memory data is sampled only here.
  assign acc_err   = (mem_addr >= DEPTH_W) | mem_dmem_error;
  assign acc_rdata = (we_q || acc_err) ? '0 : mem_valM;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q          <= PORT_C;
      rr_q           <= PORT_C;
      we_q           <= 1'b0;
      wait_q         <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
      c_gnt          <= 1'b0;
      d_gnt          <= 1'b0;
      c_rvalid       <= 1'b0;
      d_rvalid       <= 1'b0;
      c_rdata        <= '0;
      d_rdata        <= '0;
      c_err          <= 1'b0;
      d_err          <= 1'b0;
    end else begin
      c_gnt          <= 1'b0;
      d_gnt          <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
      c_rvalid       <= 1'b0;
      d_rvalid       <= 1'b0;
      c_rdata        <= '0;
      d_rdata        <= '0;
      c_err          <= 1'b0;
      d_err          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q          <= pick_win;
            we_q           <= sel_we;
            mem_addr       <= sel_addr;
            mem_write_data <= sel_wdata;
            c_gnt          <= (pick_win == PORT_C);
            d_gnt          <= (pick_win == PORT_D);
            // Out-of-range accesses never reach the memory.
            mem_write_flag <= sel_we && sel_in_range;
            mem_read_flag  <= !sel_we && sel_in_range;
            rr_q           <= other_port(pick_win);
            if (pick_win == PORT_D) begin
              wait_q <= '0;
            end else if (d_lost && (wait_q != WCNT_W'(MAX_WAIT))) begin
              wait_q <= wait_q + WCNT_W'(1);
            end
          end
        end
        ACCESS: begin
          if (win_q == PORT_C) begin
            c_rvalid <= 1'b1;
            c_rdata  <= acc_rdata;
            c_err    <= acc_err;
          end else begin
            d_rvalid <= 1'b1;
            d_rdata  <= acc_rdata;
            d_err    <= acc_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level model (reference memory + arbitration rules).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int W        = 32;
  localparam int DEPTH    = 11;
  localparam int MAXW     = 4;
  localparam logic [W-1:0] BAD_ADDR = 32'd7;
  localparam logic [W-1:0] DEPTH_W  = 32'd11;

  typedef struct packed {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [W-1:0] c_addr, c_wdata, c_rdata;
  logic         d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic [W-1:0] mem_addr, mem_write_data, mem_valM;
  logic         mem_write_flag, mem_read_flag, mem_dmem_error;
  state_e       dbg_state;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
    .mem_valM(mem_valM), .mem_dmem_error(mem_dmem_error),
    .dbg_state(dbg_state)
  );

  // Bench-side memory: 16 words, word 7 is a faulty cell (error, writes ignored).
  logic [W-1:0] mem [16];
  logic [W-1:0] init_val [16];
  bit           mem_loaded = 1'b0;
  assign mem_valM       = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : '0;
  assign mem_dmem_error = (mem_addr >= DEPTH_W) || (mem_addr == BAD_ADDR);
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
    end else if (mem_write_flag && (mem_addr < 32'd16) && (mem_addr != BAD_ADDR)) begin
      mem[mem_addr[3:0]] <= mem_write_data;
    end
  end

  // ---------------- model / scoreboard state ----------------
  logic [W-1:0] ref_mem [16];
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  txn_t         c_txq[$], d_txq[$];
  txn_t         c_cur, d_cur, resp_txn;
  bit           c_act, d_act, prev_c, prev_d, resp_due;
  int           resp_port;
  int           d_waits, rr_next;
  int           gap_pct;
  int           grant_log[$];
  int           wr_pulses, rd_pulses;
  int           n_checks, n_fail;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    if (!c_act && c_txq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      c_cur = c_txq.pop_front();
      c_act = 1'b1;
    end
    if (!d_act && d_txq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      d_cur = d_txq.pop_front();
      d_act = 1'b1;
    end
    c_req = c_act; c_we = c_cur.we; c_addr = c_cur.addr; c_wdata = c_cur.wdata;
    d_req = d_act; d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata;
    prev_c = c_act;
    prev_d = d_act;
  endtask

  // ---------------- monitor / model ----------------
  task automatic monitor();
    int   port, exp_win;
    txn_t t;
    bit   in_range, err;
    logic [W-1:0] exp_rd;

    check("c_rvalid", c_rvalid, resp_due && resp_port == 0);
    check("d_rvalid", d_rvalid, resp_due && resp_port == 1);
    if (resp_due) begin
      exp_rd = exp_q.pop_front();
      err    = exp_err_q.pop_front();
      if (resp_port == 0) begin
        check("c_rdata", c_rdata, exp_rd);
        check("c_err", c_err, err);
      end else begin
        check("d_rdata", d_rdata, exp_rd);
        check("d_err", d_err, err);
      end
      if (resp_txn.we && !err) ref_mem[resp_txn.addr[3:0]] = resp_txn.wdata;
      resp_due = 1'b0;
    end

    check("strobe_excl", mem_read_flag & mem_write_flag, 0);
    check("gnt_excl", c_gnt & d_gnt, 0);
    if (mem_write_flag) wr_pulses++;
    if (mem_read_flag)  rd_pulses++;

    if (c_gnt || d_gnt) begin
      port = d_gnt ? 1 : 0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (prev_c && prev_d) exp_win = rr_next;
      else                  exp_win = prev_d ? 1 : 0;
      rr_next = (port == 0) ? 1 : 0;
`else
      if (prev_c && prev_d) begin
        exp_win = (d_waits == MAXW) ? 1 : 0;
        if (exp_win == 1)       d_waits = 0;
        else if (d_waits < MAXW) d_waits++;
      end else begin
        exp_win = prev_d ? 1 : 0;
        if (prev_d) d_waits = 0;
      end
`endif
      check("winner", port, exp_win);
      check("gnt_has_req", (port == 1) ? d_act : c_act, 1);
      grant_log.push_back(port);
      t = (port == 1) ? d_cur : c_cur;
      in_range = (t.addr < DEPTH_W);
      check("wr_strobe", mem_write_flag, t.we && in_range);
      check("rd_strobe", mem_read_flag, !t.we && in_range);
      if (in_range) check("mem_addr", mem_addr, t.addr);
      if (t.we && in_range) check("mem_wdata", mem_write_data, t.wdata);
      err = !in_range || (t.addr == BAD_ADDR);
      exp_q.push_back((!t.we && !err) ? ref_mem[t.addr[3:0]] : '0);
      exp_err_q.push_back(err);
      resp_txn  = t;
      resp_port = port;
      resp_due  = 1'b1;
      if (port == 1) d_act = 1'b0;
      else           c_act = 1'b0;
    end else begin
      check("stray_wr", mem_write_flag, 0);
      check("stray_rd", mem_read_flag, 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      step();
      n++;
      busy = (c_txq.size() > 0) || (d_txq.size() > 0) || c_act || d_act || resp_due;
    end
    check("drain_done", busy, 0);
  endtask

  task automatic clear_model();
    c_txq.delete(); d_txq.delete(); exp_q.delete(); exp_err_q.delete();
    c_act = 1'b0; d_act = 1'b0; resp_due = 1'b0;
    prev_c = 1'b0; prev_d = 1'b0;
    d_waits = 0; rr_next = 0;
    c_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, w0, r0;
    txn_t t;
    n_checks = 0; n_fail = 0; wr_pulses = 0; rd_pulses = 0; gap_pct = 0;
    c_cur = '0; d_cur = '0; resp_txn = '0; resp_port = 0;
    c_we = 0; c_addr = '0; c_wdata = '0; d_we = 0; d_addr = '0; d_wdata = '0;
    clear_model();
    for (int i = 0; i < 16; i++) init_val[i] = $urandom;
    init_val[3] = 32'h1234;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val[i];

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_c_gnt", c_gnt, 0);       check("rst_d_gnt", d_gnt, 0);
    check("rst_c_rvalid", c_rvalid, 0); check("rst_d_rvalid", d_rvalid, 0);
    check("rst_c_rdata", c_rdata, 0);   check("rst_d_rdata", d_rdata, 0);
    check("rst_c_err", c_err, 0);       check("rst_d_err", d_err, 0);
    check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_write_data, 0);
    check("rst_wr_flag", mem_write_flag, 0);
    check("rst_rd_flag", mem_read_flag, 0);
    check("rst_state", dbg_state, 0);
    mem_loaded = 1'b1;
    rst_n = 1'b1;

    // C read addr 3: gnt and read strobe one cycle after req, data the next cycle
    c_txq.push_back('{we: 1'b0, addr: 32'd3, wdata: '0});
    step();
    step();
    check("t1_gnt_latency", c_gnt, 1);
    check("t1_rd_strobe", mem_read_flag, 1);
    step();
    check("t1_rdata", c_rdata, 32'h1234);
    check("t1_err", c_err, 0);
    drain(20);

    // D write addr 5, then C reads it back
    w0 = wr_pulses;
    d_txq.push_back('{we: 1'b1, addr: 32'd5, wdata: 32'hBEEF});
    drain(20);
    c_txq.push_back('{we: 1'b0, addr: 32'd5, wdata: '0});
    drain(20);
    check("t2_wr_pulses", wr_pulses - w0, 1);
    check("t2_ref_mem5", ref_mem[5], 32'hBEEF);

    // Out-of-range read: no strobe, error response
    w0 = wr_pulses; r0 = rd_pulses;
    c_txq.push_back('{we: 1'b0, addr: 32'd11, wdata: '0});
    drain(20);
    check("t3_no_strobe", (wr_pulses - w0) + (rd_pulses - r0), 0);

    // Continuous contention
    grant_log.delete();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    n = rr_next;
`else
    n = 0;
`endif
    for (int i = 0; i < 10; i++) c_txq.push_back('{we: 1'b0, addr: 32'($urandom_range(0, 10)), wdata: '0});
    for (int i = 0; i < 2; i++)  d_txq.push_back('{we: 1'b0, addr: 32'($urandom_range(0, 10)), wdata: '0});
    drain(200);
    check("t4_grant_count", grant_log.size(), 12);
    if (grant_log.size() == 12) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++) check("t4_rr_order", grant_log[i], (n + i) % 2);
`else
      for (int i = 0; i < 10; i++) check("t4_fp_order", grant_log[i], (i == 4 || i == 9) ? 1 : 0);
`endif
    end

    // Reset during the ACCESS cycle of a D write to addr 2
    d_txq.push_back('{we: 1'b1, addr: 32'd2, wdata: 32'hCAFE_0002});
    n = 0;
    do begin step(); n++; end while (!d_gnt && n < 10);
    check("t5_gnt_seen", d_gnt, 1);
    check("t5_wr_before_rst", mem_write_flag, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_wr_drop", mem_write_flag, 0);
    check("t5_gnt_drop", d_gnt, 0);
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check("t5_no_rvalid", c_rvalid | d_rvalid, 0);
      check("t5_no_strobe", mem_write_flag | mem_read_flag, 0);
    end
    rst_n = 1'b1;
    c_txq.push_back('{we: 1'b0, addr: 32'd2, wdata: '0});
    drain(20);
    check("t5_mem2_kept", ref_mem[2], init_val[2]);

    // Randomized traffic on both ports
    gap_pct = 40;
    for (int i = 0; i < 150; i++) begin
      t.we    = $urandom_range(0, 1);
      t.addr  = 32'($urandom_range(0, 13));
      t.wdata = $urandom;
      if ($urandom_range(0, 1) == 1) d_txq.push_back(t);
      else                           c_txq.push_back(t);
    end
    drain(5000);
    gap_pct = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sequences and shares the single-port data memory between two requesters: the CPU memory stage (port C) and a debug/program-loader port (port D). Each granted request is converted into one clean, registered read-or-write strobe to the memory. Out-of-range addresses are filtered before they reach the memory. Read data and the error status are returned through a registered response. The block sits between the pipeline's memory stage and the data memory.

Parameters:
DATA_WID, 32, data and address width; shared with the codebase header macro of the same name.
MEM_DEPTH, 11, number of memory words; valid addresses are 0..MEM_DEPTH-1.
MAX_WAIT, 4, number of consecutive lost arbitrations after which port D is forced to win.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
c_req  in  1  port C request; held until c_gnt.
c_we  in  1  port C write (1) or read (0).
c_addr  in  DATA_WID  port C word address.
c_wdata  in  DATA_WID  port C write data.
c_gnt  out  1  one-cycle pulse: port C request accepted.
c_rvalid  out  1  one-cycle pulse: port C response valid (issued for reads and writes).
c_rdata  out  DATA_WID  port C read data; 0 for writes and errors.
c_err  out  1  port C error status; qualified by c_rvalid.
d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: same directions, widths and meanings for port D.
mem_addr  out  DATA_WID  address to the memory.
mem_write_data  out  DATA_WID  write data to the memory.
mem_write_flag  out  1  memory write strobe.
mem_read_flag  out  1  memory read strobe.
mem_valM  in  DATA_WID  memory read data (combinational from mem_addr).
mem_dmem_error  in  1  memory range error.

Behaviour:
- Reset: every output is 0; state = IDLE; wait counter = 0; round-robin pointer = C. Asserting reset mid-access drops the strobes immediately. No partial transaction survives reset and no response is issued for it.
- All outputs are registered. mem_write_flag and mem_read_flag are never high together.
- States:
  - IDLE: if any req, pick a winner and latch its we/addr/wdata; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (1 cycle): winner's gnt=1. If latched addr < MEM_DEPTH, drive the matching strobe. If addr >= MEM_DEPTH, drive no strobe. Capture rdata = mem_valM for reads (0 for writes), and err = (addr >= MEM_DEPTH) | mem_dmem_error. Go to RESP.
  - RESP (1 cycle): winner's rvalid=1 with rdata/err; go to IDLE.
- Latency: req sampled at cycle T gives gnt at T+1 and rvalid at T+2. Peak throughput is one access every 3 cycles.
- Arbitration (fixed priority, default):
  - C beats D.
  - Each cycle in IDLE where D requests and loses, the wait counter increments (saturating at MAX_WAIT).
  - When the counter = MAX_WAIT, D wins the next contention and the counter clears.
  - The counter also clears whenever D is granted.
- Requesters must hold req/we/addr/wdata stable until gnt. A req dropped before gnt is a protocol violation: behaviour is undefined, but no strobe may fire without a grant.
- A new req from the requester just served is considered only in the next IDLE cycle.
- Read data is sampled in the ACCESS cycle; memory output is never re-read later.

Optional Feature:
Macro DMEM_ARB_ROUND_ROBIN_EN.
- Defined: contention is resolved strictly alternately. The pointer flips to the other port after each grant, and the wait counter and MAX_WAIT are unused.
- Undefined: fixed priority with starvation counter, as described in Behaviour.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/RESP), requester IDs (PORT_C=0, PORT_D=1), MEM_DEPTH constant; DATA_WID comes from the common header.
- One sub-module, dmem_arb_pick: combinational winner selection from c_req, d_req, the wait counter and the RR pointer. This keeps the policy swappable; the FSM and registers stay in dmem_arbiter.

Test Plan:
- C read addr 3 with memory[3]=0x1234: mem_read_flag high for 1 cycle at T+1; c_rvalid at T+2 with c_rdata=0x1234 and c_err=0.
- D write addr 5 data 0xBEEF, then C read addr 5: exactly one mem_write_flag pulse; later c_rdata=0xBEEF.
- C read addr 11 (out of range): no strobe asserted; c_rvalid with c_err=1 and c_rdata=0.
- C and D both requesting continuously (fixed priority, MAX_WAIT=4): D granted after every 4 C grants; the sequence never starves D. With DMEM_ARB_ROUND_ROBIN_EN: grants alternate C, D, C, D.
- rst_n pulled low during ACCESS of a write: strobes drop asynchronously; no rvalid is issued; the first post-reset request completes normally.
- Property check, all scenarios: mem_write_flag & mem_read_flag is never 1, and each gnt pulse is followed by exactly one rvalid to the same port 1 cycle later.
